// File: rtl/otter_io_responder.sv
// otter_io_responder: OTTER IOBUS slave with switch/button inputs, LED and 7-seg registers,
// and a 32-bit compare timer. Define OTTER_IO_PRESCALE_EN to add the TPRE tick prescaler.
module otter_io_responder #(
  parameter logic [31:0] IO_BASE   = 32'h1100_0000,
  parameter int unsigned SW_WIDTH  = 16,
  parameter int unsigned BTN_WIDTH = 5,
  parameter int unsigned LED_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [31:0]          IOBUS_ADDR,
  input  logic [31:0]          IOBUS_OUT,
  input  logic                 IOBUS_WR,
  output logic [31:0]          IOBUS_IN,
  input  logic [SW_WIDTH-1:0]  SWITCHES,
  input  logic [BTN_WIDTH-1:0] BUTTONS,
  output logic [LED_WIDTH-1:0] LEDS,
  output logic [15:0]          SSEG_DATA,
  output logic                 TIMER_IRQ
);

  localparam logic [31:0] OffSw     = 32'h00;
  localparam logic [31:0] OffBtn    = 32'h04;
  localparam logic [31:0] OffBtnEvt = 32'h08;
  localparam logic [31:0] OffLeds   = 32'h20;
  localparam logic [31:0] OffSseg   = 32'h40;
  localparam logic [31:0] OffTctrl  = 32'h60;
  localparam logic [31:0] OffTcount = 32'h64;
  localparam logic [31:0] OffTcmp   = 32'h68;
  localparam logic [31:0] OffTstat  = 32'h6C;
`ifdef OTTER_IO_PRESCALE_EN
  localparam logic [31:0] OffTpre   = 32'h70;
`endif

  typedef enum logic [1:0] {TmStopped, TmOneShot, TmReload} tmode_e;

  logic [SW_WIDTH-1:0]  sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
  logic [BTN_WIDTH-1:0] btn_meta_q, btn_meta_d, btn_sync_q, btn_sync_d;
  logic [BTN_WIDTH-1:0] btn_prev_q, btn_prev_d, btn_evt_q, btn_evt_d;
  logic [LED_WIDTH-1:0] led_q, led_d;
  logic [15:0]          sseg_q, sseg_d;
  logic [2:0]           tctrl_q, tctrl_d;
  logic [31:0]          tcount_q, tcount_d, tcmp_q, tcmp_d;
  logic                 match_q, match_d, irq_q, irq_d;
  logic                 tick, match_hit;
  tmode_e               tmode;
`ifdef OTTER_IO_PRESCALE_EN
  logic [15:0]          tpre_q, tpre_d, pre_cnt_q, pre_cnt_d;
  logic                 we_tpre;
`endif

  // Full-address compares against aligned offsets also reject misaligned accesses.
  logic we_btn_evt, we_leds, we_sseg, we_tctrl, we_tcount, we_tcmp, we_tstat;
  assign we_btn_evt = IOBUS_WR && (IOBUS_ADDR == IO_BASE + OffBtnEvt);
  assign we_leds    = IOBUS_WR && (IOBUS_ADDR == IO_BASE + OffLeds);
  assign we_sseg    = IOBUS_WR && (IOBUS_ADDR == IO_BASE + OffSseg);
  assign we_tctrl   = IOBUS_WR && (IOBUS_ADDR == IO_BASE + OffTctrl);
  assign we_tcount  = IOBUS_WR && (IOBUS_ADDR == IO_BASE + OffTcount);
  assign we_tcmp    = IOBUS_WR && (IOBUS_ADDR == IO_BASE + OffTcmp);
  assign we_tstat   = IOBUS_WR && (IOBUS_ADDR == IO_BASE + OffTstat);
`ifdef OTTER_IO_PRESCALE_EN
  assign we_tpre    = IOBUS_WR && (IOBUS_ADDR == IO_BASE + OffTpre);
`endif

  // Input sampling, button edge flags and plain output registers.
  always_comb begin
    sw_meta_d  = SWITCHES;
    sw_sync_d  = sw_meta_q;
    btn_meta_d = BUTTONS;
    btn_sync_d = btn_meta_q;
    btn_prev_d = btn_sync_q;
    btn_evt_d  = btn_evt_q;
    if (we_btn_evt) begin
      btn_evt_d = btn_evt_q & ~IOBUS_OUT[BTN_WIDTH-1:0];
    end
    btn_evt_d = btn_evt_d | (btn_sync_q & ~btn_prev_q);
    led_d  = we_leds ? IOBUS_OUT[LED_WIDTH-1:0] : led_q;
    sseg_d = we_sseg ? IOBUS_OUT[15:0] : sseg_q;
    tcmp_d = we_tcmp ? IOBUS_OUT : tcmp_q;
  end

  always_comb begin
    tmode = TmStopped;
    if (tctrl_q[0]) begin
      tmode = tctrl_q[1] ? TmReload : TmOneShot;
    end
  end

`ifdef OTTER_IO_PRESCALE_EN
  always_comb begin
    tpre_d    = we_tpre ? IOBUS_OUT[15:0] : tpre_q;
    tick      = tctrl_q[0] && (pre_cnt_q == tpre_q);
    pre_cnt_d = pre_cnt_q + 16'd1;
    if (!tctrl_q[0] || we_tpre || tick) begin
      pre_cnt_d = '0;
    end
  end
`else
  always_comb begin
    tick = tctrl_q[0];
  end
`endif

  // Timer next state; CPU writes are applied last so they win over hardware updates.
  always_comb begin
    tcount_d  = tcount_q;
    tctrl_d   = tctrl_q;
    match_hit = 1'b0;
    if (tick) begin
      match_hit = (tcount_q == tcmp_q);
      unique case (tmode)
        TmReload: begin
          tcount_d = match_hit ? 32'd0 : tcount_q + 32'd1;
        end
        TmOneShot: begin
          if (match_hit) begin
            tctrl_d[0] = 1'b0;
          end else begin
            tcount_d = tcount_q + 32'd1;
          end
        end
        default: begin
        end
      endcase
    end
    if (we_tctrl) begin
      tctrl_d = IOBUS_OUT[2:0];
    end
    if (we_tcount) begin
      tcount_d = IOBUS_OUT;
    end
    match_d = match_hit | (match_q & ~(we_tstat & IOBUS_OUT[0]));
    irq_d   = match_q & tctrl_q[2];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      btn_meta_q <= '0;
      btn_sync_q <= '0;
      btn_prev_q <= '0;
      btn_evt_q  <= '0;
      led_q      <= '0;
      sseg_q     <= '0;
      tctrl_q    <= '0;
      tcount_q   <= '0;
      tcmp_q     <= '0;
      match_q    <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      sw_meta_q  <= sw_meta_d;
      sw_sync_q  <= sw_sync_d;
      btn_meta_q <= btn_meta_d;
      btn_sync_q <= btn_sync_d;
      btn_prev_q <= btn_prev_d;
      btn_evt_q  <= btn_evt_d;
      led_q      <= led_d;
      sseg_q     <= sseg_d;
      tctrl_q    <= tctrl_d;
      tcount_q   <= tcount_d;
      tcmp_q     <= tcmp_d;
      match_q    <= match_d;
      irq_q      <= irq_d;
    end
  end

`ifdef OTTER_IO_PRESCALE_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tpre_q    <= '0;
      pre_cnt_q <= '0;
    end else begin
      tpre_q    <= tpre_d;
      pre_cnt_q <= pre_cnt_d;
    end
  end
`endif

  // Read mux sees only registered state, never the raw board inputs.
  always_comb begin
    IOBUS_IN = '0;
    unique case (IOBUS_ADDR)
      IO_BASE + OffSw:     IOBUS_IN[SW_WIDTH-1:0]  = sw_sync_q;
      IO_BASE + OffBtn:    IOBUS_IN[BTN_WIDTH-1:0] = btn_sync_q;
      IO_BASE + OffBtnEvt: IOBUS_IN[BTN_WIDTH-1:0] = btn_evt_q;
      IO_BASE + OffLeds:   IOBUS_IN[LED_WIDTH-1:0] = led_q;
      IO_BASE + OffSseg:   IOBUS_IN[15:0]          = sseg_q;
      IO_BASE + OffTctrl:  IOBUS_IN[2:0]           = tctrl_q;
      IO_BASE + OffTcount: IOBUS_IN                = tcount_q;
      IO_BASE + OffTcmp:   IOBUS_IN                = tcmp_q;
      IO_BASE + OffTstat:  IOBUS_IN[0]             = match_q;
`ifdef OTTER_IO_PRESCALE_EN
      IO_BASE + OffTpre:   IOBUS_IN[15:0]          = tpre_q;
`endif
      default:             IOBUS_IN                = '0;
    endcase
  end

  assign LEDS      = led_q;
  assign SSEG_DATA = sseg_q;
  assign TIMER_IRQ = irq_q;

endmodule

// File: doc/otter_io_responder.md
Name: otter_io_responder

Overview:
- Memory-mapped I/O responder on the far side of the OTTER IOBUS.
- The CPU's memory stage drives IOBUS_ADDR, IOBUS_OUT and IOBUS_WR. This block decodes them, holds the output registers (LEDs, seven-segment data), samples the board inputs (switches, buttons), and provides a 32-bit timer with a compare interrupt.
- It returns read data on IOBUS_IN.

Parameters:
- IO_BASE, 32'h1100_0000, base address of the I/O window; register offsets are relative to it.
- SW_WIDTH, 16, number of switch inputs.
- BTN_WIDTH, 5, number of button inputs.
- LED_WIDTH, 16, width of the LED register.

Ports:
- CLK  input  1  system clock (the same clock as the CPU).
- RST_N  input  1  asynchronous, active-low reset.
- IOBUS_ADDR  input  32  byte address from the CPU.
- IOBUS_OUT  input  32  write data from the CPU.
- IOBUS_WR  input  1  write strobe; one cycle per store.
- IOBUS_IN  output  32  read data to the CPU.
- SWITCHES  input  SW_WIDTH  asynchronous board switches.
- BUTTONS  input  BTN_WIDTH  asynchronous board buttons.
- LEDS  output  LED_WIDTH  LED register.
- SSEG_DATA  output  16  seven-segment display value register.
- TIMER_IRQ  output  1  level interrupt: MATCH & IRQ_EN.

Behaviour:
- Reset (RST_N=0, asynchronous): every register, synchronizer flop, counter and output is 0. This includes IOBUS_IN, LEDS, SSEG_DATA and TIMER_IRQ.
- Register map (offset from IO_BASE; access type):
  - 0x00 SW: RO; 2-flop-synchronized SWITCHES, zero-extended.
  - 0x04 BTN: RO; 2-flop-synchronized BUTTONS.
  - 0x08 BTN_EVT: sticky rising-edge flags per button; write-1-to-clear.
  - 0x20 LEDS: RW; written from IOBUS_OUT[LED_WIDTH-1:0].
  - 0x40 SSEG: RW; written from IOBUS_OUT[15:0].
  - 0x60 TCTRL: RW; bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN.
  - 0x64 TCOUNT: RW; 32-bit.
  - 0x68 TCMP: RW; 32-bit.
  - 0x6C TSTAT: bit0 MATCH, sticky; write-1-to-clear.
- Write path:
  - Registered on the rising CLK edge when IOBUS_WR=1 and IOBUS_ADDR decodes to a writable register.
  - The full 32-bit address is compared, and IOBUS_ADDR[1:0] must be 00.
  - Unmapped or misaligned writes are ignored.
  - Read-only fields ignore writes.
- Read path:
  - IOBUS_IN is a combinational mux of registered state, selected by IOBUS_ADDR; there are no combinational paths from SWITCHES or BUTTONS.
  - Unmapped, misaligned or out-of-window reads return 32'h0.
  - Reads have no side effects.
- Button events:
  - A flag sets when the synchronized button is 1 and its previous sample was 0.
  - Set and clear in the same cycle: set wins.
- Timer states, decoded from EN and AUTO_RELOAD:
  - STOPPED (EN=0): TCOUNT holds.
  - RUNNING (EN=1): TCOUNT increments by 1 per tick (every cycle unless prescaled); it wraps 32'hFFFF_FFFF to 0 with no flag.
  - MATCH, evaluated on the cycle the pre-increment TCOUNT equals TCMP while RUNNING:
    - MATCH is set.
    - If AUTO_RELOAD=1: TCOUNT loads 0 and the timer stays RUNNING.
    - Otherwise: TCOUNT holds the match value and EN clears to 0, giving STOPPED.
- Timer priorities:
  - A CPU write to TCOUNT in the same cycle as an increment or reload: the write wins.
  - A write of EN=1 in the same cycle as a one-shot auto-clear: the write wins.
  - A MATCH set in the same cycle as a W1C on TSTAT: set wins.
- TIMER_IRQ is registered and asserts the cycle after MATCH and IRQ_EN are both 1.
- Latency:
  - Register writes are visible on IOBUS_IN one cycle after the write edge.
  - Switch changes appear on SW after 2 edges.
- Reset mid-operation: all state clears immediately, including an in-flight timer; no partial write is retained.

Optional Feature:
- Macro: OTTER_IO_PRESCALE_EN.
- Defined:
  - Adds a 16-bit RW register TPRE at offset 0x70 (reset 0) and an internal 16-bit prescale counter.
  - A timer tick is produced when the prescale counter equals TPRE; the counter then returns to 0. Otherwise it increments while EN=1.
  - TPRE=0 gives one tick per cycle.
  - The prescale counter clears whenever EN=0 or TPRE is written.
- Not defined:
  - One tick every cycle while EN=1.
  - Offset 0x70 is unmapped: reads return 0, writes are ignored.

Test Plan:
- Reset: hold RST_N=0 with SWITCHES=16'hA5A5 and a prior LEDS write. Release, read 0x00 -> 0 until 2 edges elapse, then 32'h0000_A5A5. LEDS=0, TIMER_IRQ=0.
- LED/SSEG write-back: write 32'hDEAD_BEEF to 0x20 and 32'h1234_5678 to 0x40 -> LEDS=16'hBEEF, SSEG_DATA=16'h5678; reads return zero-extended values. A write to 0x24 or 0x21 leaves both unchanged.
- One-shot timer:
  - TCMP=5, TCOUNT=0, TCTRL=3'b101.
  - MATCH sets 6 ticks after the enable edge; TCOUNT reads 5 and EN reads 0.
  - TIMER_IRQ=1 the next cycle.
  - Writing 1 to 0x6C drops TIMER_IRQ one cycle later.
- Auto-reload with collisions:
  - TCMP=3, TCTRL=3'b011: TCOUNT sequence 0,1,2,3,0,1…
  - A W1C on TSTAT landing on the match cycle leaves MATCH=1.
  - A TCOUNT write of 100 on an increment cycle reads back 100.
- Buttons: pulse BUTTONS[2] for 3 cycles -> BTN_EVT=32'h4. A second pulse before the clear keeps 32'h4; a write of 32'h4 clears it to 0; a write of 32'h1 leaves 32'h4.
- Prescale (OTTER_IO_PRESCALE_EN defined): TPRE=3, TCMP=2, EN=1 -> MATCH after 12 cycles. Without the macro, a read of 0x70 returns 0 and MATCH follows after 3 cycles.
